// File: rtl/pc_gen.sv
// Fetch-PC generator and redirect sequencer feeding the instruction-alignment checker.
// Optional performance counters are enabled with `define PCGEN_PERF_CNT_EN.
module pc_gen #(
  parameter int unsigned             PC_WIDTH   = 64,
  parameter int unsigned             ADDR_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0]     RESET_PC   = PC_WIDTH'(64'h0000_0000_8000_0000),
  parameter int unsigned             PC_INC     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] bpu_addr_i,
  input  logic                  bpu_taken_i,
  input  logic [ADDR_WIDTH-1:0] bru_addr_i,
  input  logic                  bru_miss_i,
  input  logic                  trap_valid_i,
  input  logic [PC_WIDTH-1:0]   trap_addr_i,
  input  logic                  if_ready_i,
  input  logic                  ialign_exc_i,
  input  logic [ADDR_WIDTH-1:0] ialign_addr_i,
  output logic [PC_WIDTH-1:0]   pc_o,
  output logic                  pc_valid_o,
  output logic                  exc_valid_o,
  output logic [ADDR_WIDTH-1:0] exc_addr_o
`ifdef PCGEN_PERF_CNT_EN
  ,
  output logic [63:0]           perf_fetch_cnt_o,
  output logic [63:0]           perf_redirect_cnt_o
`endif
);

  // Redirect targets and the PC share one address space; refuse to build otherwise.
  if (PC_WIDTH != ADDR_WIDTH) begin : g_width_mismatch
    $error("pc_gen: PC_WIDTH (%0d) must equal ADDR_WIDTH (%0d)", PC_WIDTH, ADDR_WIDTH);
  end

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e state;
  logic   fire;

  // Request validity never looks at if_ready_i, so the fetch port sees a stable request.
  assign pc_valid_o = (state == FETCH) && !ialign_exc_i;
  assign fire       = pc_valid_o && if_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= BOOT;
      pc_o        <= RESET_PC;
      exc_valid_o <= 1'b0;
      exc_addr_o  <= '0;
    end else begin
      exc_valid_o <= 1'b0;
      case (state)
        BOOT: begin
          state <= FETCH;
        end
        FETCH: begin
          // Trap wins over everything, including a misaligned verdict on the old PC.
          if (trap_valid_i) begin
            pc_o <= trap_addr_i;
          end else if (ialign_exc_i) begin
            state       <= HALT;
            exc_valid_o <= 1'b1;
            exc_addr_o  <= ialign_addr_i;
          end else if (bru_miss_i) begin
            pc_o <= PC_WIDTH'(bru_addr_i);
          end else if (bpu_taken_i && fire) begin
            pc_o <= PC_WIDTH'(bpu_addr_i);
          end else if (fire) begin
            pc_o <= pc_o + PC_WIDTH'(PC_INC);
          end
        end
        HALT: begin
          if (trap_valid_i) begin
            pc_o  <= trap_addr_i;
            state <= FETCH;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

`ifdef PCGEN_PERF_CNT_EN
  logic redirect_taken;

  // Counts the trap and mispredict redirects that actually steered the PC while fetching.
  assign redirect_taken = (state == FETCH) &&
                          (trap_valid_i || (!ialign_exc_i && bru_miss_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fetch_cnt_o    <= '0;
      perf_redirect_cnt_o <= '0;
    end else begin
      if (fire) begin
        perf_fetch_cnt_o <= perf_fetch_cnt_o + 64'd1;
      end
      if (redirect_taken) begin
        perf_redirect_cnt_o <= perf_redirect_cnt_o + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed steps push expected post-edge state, a monitor pops and compares.
module tb_pc_gen;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] bpu_addr = '0;
  logic        bpu_taken = 1'b0;
  logic [63:0] bru_addr = '0;
  logic        bru_miss = 1'b0;
  logic        trap_valid = 1'b0;
  logic [63:0] trap_addr = '0;
  logic        if_ready = 1'b0;
  logic        ialign_exc = 1'b0;
  logic [63:0] ialign_addr = '0;
  logic [63:0] pc;
  logic        pc_valid;
  logic        exc_valid;
  logic [63:0] exc_addr;
`ifdef PCGEN_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_redirect_cnt;
`endif

  typedef struct {
    string       tag;
    logic [63:0] pc;
    logic        exc;
    logic [63:0] eaddr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_gen dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bpu_addr_i    (bpu_addr),
    .bpu_taken_i   (bpu_taken),
    .bru_addr_i    (bru_addr),
    .bru_miss_i    (bru_miss),
    .trap_valid_i  (trap_valid),
    .trap_addr_i   (trap_addr),
    .if_ready_i    (if_ready),
    .ialign_exc_i  (ialign_exc),
    .ialign_addr_i (ialign_addr),
    .pc_o          (pc),
    .pc_valid_o    (pc_valid),
    .exc_valid_o   (exc_valid),
    .exc_addr_o    (exc_addr)
`ifdef PCGEN_PERF_CNT_EN
    ,
    .perf_fetch_cnt_o    (perf_fetch_cnt),
    .perf_redirect_cnt_o (perf_redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bpu_taken  = 1'b0;
    bru_miss   = 1'b0;
    trap_valid = 1'b0;
    ialign_exc = 1'b0;
  endtask

  // Called at a negedge with inputs already applied; returns at the following negedge.
  task automatic step(input string tag, input logic exp_valid, input logic [63:0] exp_pc,
                      input logic exp_exc, input logic [63:0] exp_eaddr);
    exp_t e;
    #1;
    check({tag, ".pc_valid"}, 64'(pc_valid), 64'(exp_valid));
    e.tag   = tag;
    e.pc    = exp_pc;
    e.exc   = exp_exc;
    e.eaddr = exp_eaddr;
    sb.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, ".pc"}, pc, e.pc);
      check({e.tag, ".exc_valid"}, 64'(exc_valid), 64'(e.exc));
      check({e.tag, ".exc_addr"}, exc_addr, e.eaddr);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    rst = 1'b1; if_ready = 1'b1;
    step("reset", 1'b0, RST_PC, 1'b0, 64'h0);
    rst = 1'b0;
    step("boot", 1'b0, RST_PC, 1'b0, 64'h0);
    step("seq1", 1'b1, 64'h8000_0004, 1'b0, 64'h0);
    step("seq2", 1'b1, 64'h8000_0008, 1'b0, 64'h0);
    step("seq3", 1'b1, 64'h8000_000C, 1'b0, 64'h0);
    step("seq4", 1'b1, 64'h8000_0010, 1'b0, 64'h0);

    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 64'h8000_0010, 1'b0, 64'h0);
    if_ready = 1'b1;
    step("unstall", 1'b1, 64'h8000_0014, 1'b0, 64'h0);

    bru_miss = 1'b1; bru_addr = 64'h8000_1000;
    bpu_taken = 1'b1; bpu_addr = 64'h8000_2000;
    step("bru_over_bpu", 1'b1, 64'h8000_1000, 1'b0, 64'h0);
    bru_miss = 1'b0;
    step("bpu_fire", 1'b1, 64'h8000_2000, 1'b0, 64'h0);
    if_ready = 1'b0;
    bpu_addr = 64'h8000_3000;
    step("bpu_nofire", 1'b1, 64'h8000_2000, 1'b0, 64'h0);
    idle(); if_ready = 1'b1;
    step("seq5", 1'b1, 64'h8000_2004, 1'b0, 64'h0);

    bru_miss = 1'b1; bru_addr = 64'h8000_0102;
    ialign_exc = 1'b1; ialign_addr = 64'h8000_0102;
    step("misalign", 1'b0, 64'h8000_2004, 1'b1, 64'h8000_0102);
    ialign_exc = 1'b0;
    bru_addr = 64'h8000_3000; bpu_taken = 1'b1;
    step("halt_bru", 1'b0, 64'h8000_2004, 1'b0, 64'h8000_0102);
    idle(); ialign_exc = 1'b1; ialign_addr = 64'h8000_0F02;
    step("halt_exc", 1'b0, 64'h8000_2004, 1'b0, 64'h8000_0102);
    idle(); trap_valid = 1'b1; trap_addr = 64'h8000_0200;
    step("halt_trap", 1'b0, 64'h8000_0200, 1'b0, 64'h8000_0102);
    idle();
    step("resume", 1'b1, 64'h8000_0204, 1'b0, 64'h8000_0102);

    trap_valid = 1'b1; trap_addr = 64'h8000_0400;
    ialign_exc = 1'b1; ialign_addr = 64'h8000_0206;
    step("trap_over_exc", 1'b0, 64'h8000_0400, 1'b0, 64'h8000_0102);
    idle();
    step("after_trap", 1'b1, 64'h8000_0404, 1'b0, 64'h8000_0102);

    if_ready = 1'b0; trap_valid = 1'b1; trap_addr = 64'h8000_0500;
    step("trap_stall", 1'b1, 64'h8000_0500, 1'b0, 64'h8000_0102);
    trap_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    step("trap_top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h8000_0102);
    idle(); if_ready = 1'b1;
    step("wrap", 1'b1, 64'h0, 1'b0, 64'h8000_0102);

    ialign_exc = 1'b1; ialign_addr = 64'h8000_0102;
    step("misalign2", 1'b0, 64'h0, 1'b1, 64'h8000_0102);
    idle();
    step("halt_hold", 1'b0, 64'h0, 1'b0, 64'h8000_0102);
    rst = 1'b1; trap_valid = 1'b1; trap_addr = 64'h8000_0700;
    step("halt_reset", 1'b0, RST_PC, 1'b0, 64'h0);
`ifdef PCGEN_PERF_CNT_EN
    check("perf_fetch_rst", perf_fetch_cnt, 64'h0);
    check("perf_redir_rst", perf_redirect_cnt, 64'h0);
`endif
    rst = 1'b0; idle();
    step("boot2", 1'b0, RST_PC, 1'b0, 64'h0);
    step("seq6", 1'b1, 64'h8000_0004, 1'b0, 64'h0);
`ifdef PCGEN_PERF_CNT_EN
    check("perf_fetch_one", perf_fetch_cnt, 64'h1);
`endif

    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Fetch-PC generator and redirect sequencer. Sits directly upstream of the instruction-alignment checker.
- Holds the architectural fetch PC and drives it as `pc_o` to the alignment checker (its `pc_i`) and to the I-fetch request port.
- Selects the next PC from trap, branch-mispredict, branch-predict and sequential sources.
- Consumes the checker's misaligned verdict; on a misaligned fetch it stops fetching and reports the exception until trap redirect.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset, width `PC_WIDTH`.
- PC_INC, 4, sequential increment; RV64G, no compressed instructions.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- bpu_addr_i  in  `ADDR_WIDTH`  predicted target; also routed to the checker.
- bpu_taken_i  in  1  prediction taken for the current `pc_o`.
- bru_addr_i  in  `ADDR_WIDTH`  corrected branch target; also routed to the checker.
- bru_miss_i  in  1  mispredict redirect.
- trap_valid_i  in  1  trap/exception redirect from commit.
- trap_addr_i  in  `PC_WIDTH`  trap vector or return target.
- if_ready_i  in  1  fetch port accepts the request.
- ialign_exc_i  in  1  `misaligned_exception` from the checker.
- ialign_addr_i  in  `ADDR_WIDTH`  `misaligned_addr` from the checker.
- pc_o  out  `PC_WIDTH`  current fetch PC, registered.
- pc_valid_o  out  1  fetch request valid.
- exc_valid_o  out  1  one-cycle instruction-address-misaligned pulse.
- exc_addr_o  out  `ADDR_WIDTH`  offending address, registered.

Behaviour:
- States: BOOT, FETCH, HALT.
- Reset (synchronous, has priority over all inputs, valid mid-operation):
  - state = BOOT, pc_o = RESET_PC, exc_valid_o = 0, exc_addr_o = 0.
  - Any pending request is dropped.
- BOOT: pc_valid_o = 0; unconditionally goes to FETCH next cycle.
- pc_valid_o = (state == FETCH) & ~ialign_exc_i.
  - Combinational, but depends only on registers and redirect inputs, never on if_ready_i.
- fire = pc_valid_o & if_ready_i.
- FETCH next-PC priority, first match wins:
  1. trap_valid_i: pc <= trap_addr_i. Stay in FETCH. ialign_exc_i is ignored this cycle; no exception.
  2. ialign_exc_i:
     - pc holds.
     - exc_valid_o <= 1 and exc_addr_o <= ialign_addr_i on the next edge.
     - State goes to HALT.
  3. bru_miss_i: pc <= bru_addr_i, independent of fire. An un-accepted request is cancelled.
  4. bpu_taken_i & fire: pc <= bpu_addr_i.
  5. fire: pc <= pc + PC_INC, truncated to `PC_WIDTH` (wraps modulo 2^`PC_WIDTH`).
  6. Otherwise (stall): pc holds, and pc_valid_o stays high.
- bpu_taken_i without fire is ignored. The predictor must re-present it while the PC is stalled.
- HALT:
  - pc_valid_o = 0.
  - bru_miss_i, bpu_taken_i and ialign_exc_i are ignored.
  - trap_valid_i: pc <= trap_addr_i, state goes to FETCH.
  - Reset also exits.
- exc_valid_o is high for exactly one cycle per HALT entry. exc_addr_o holds its value until the next exception or reset.
- A misaligned trap_addr_i is not checked here. The checker flags it as `pc_i` next cycle, which re-enters HALT through the normal path.
- Latency: redirect input to new pc_o is 1 cycle. Exception input to exc_valid_o is 1 cycle.
- `ADDR_WIDTH` and `PC_WIDTH` are equal; a width mismatch is an elaboration error.

Optional Feature:
- Macro: PCGEN_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt_o (64) and perf_redirect_cnt_o (64), both zeroed on reset.
  - perf_fetch_cnt_o increments on every fire.
  - perf_redirect_cnt_o increments on every taken priority-1 or priority-3 redirect.
  - Both wrap at 2^64.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then if_ready_i = 1 constantly, no redirects:
  - BOOT cycle with pc_valid_o = 0.
  - Then pc_o = 0x80000000, 0x80000004, 0x80000008 on consecutive cycles.
- if_ready_i = 0 for 3 cycles at pc 0x80000010: pc_o holds 0x80000010 with pc_valid_o = 1 throughout; advances to 0x80000014 one cycle after ready returns.
- Same cycle: bru_miss_i = 1 with bru_addr_i = 0x80001000, and bpu_taken_i = 1 with bpu_addr_i = 0x80002000 and fire → next pc_o = 0x80001000.
- bru_miss_i with bru_addr_i = 0x80000102 and checker asserting ialign_exc_i:
  - pc_valid_o = 0 that cycle.
  - Next cycle exc_valid_o = 1 for one cycle, exc_addr_o = 0x80000102, state HALT.
  - Later bru_miss_i is ignored.
  - trap_valid_i with trap_addr_i = 0x80000200 resumes fetch at 0x80000200.
- trap_valid_i and ialign_exc_i asserted together: pc_o becomes trap_addr_i, no exc_valid_o pulse.
- rst_i asserted while in HALT with exc_addr_o = 0x80000102: next cycle state BOOT, pc_o = 0x80000000, exc_addr_o = 0. With PCGEN_PERF_CNT_EN defined, both counters read 0.
